// File: rtl/pubexp_select_ctrl_pkg.sv
// Shared types and default parameters for the public-exponent selection controller.
package pubexp_pkg;

    localparam int DEF_W         = 8;
    localparam int DEF_E_START   = 3;
    localparam int DEF_MAX_TRIES = 64;

    typedef logic [DEF_W-1:0] operand_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_PHI,
        ST_LAUNCH,
        ST_WAIT_GCD,
        ST_EVAL,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/pubexp_select_ctrl_if.sv
// Request/result bundle between key-setup control and the exponent selector.
// Optional tries_out member is present when PUBEXP_TRYCNT_EN is defined.
interface pubexp_select_ctrl_if #(parameter int W = 8);

    logic         start;
    logic [W-1:0] phi;
    logic         busy;
    logic         done;
    logic         fail;
    logic [W-1:0] e_out;
`ifdef PUBEXP_TRYCNT_EN
    logic [7:0]   tries_out;
`endif

`ifdef PUBEXP_TRYCNT_EN
    modport master (output start, phi, input busy, done, fail, e_out, tries_out);
    modport slave  (input start, phi, output busy, done, fail, e_out, tries_out);
`else
    modport master (output start, phi, input busy, done, fail, e_out);
    modport slave  (input start, phi, output busy, done, fail, e_out);
`endif

endinterface

// File: rtl/pubexp_select_ctrl_gcd.sv
// Iterative Euclid GCD engine: one remainder step per cycle, gdone pulses with g valid.
module gcd_iter_core #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gdone,
    output logic [W-1:0] g
);

    logic         run_q, run_d;
    logic         gdone_q, gdone_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] g_q, g_d;

    always_comb begin
        run_d   = run_q;
        gdone_d = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        g_d     = g_q;
        if (!run_q) begin
            if (go) begin
                x_d   = a;
                y_d   = b;
                run_d = 1'b1;
            end
        end else if (y_q != '0) begin
            x_d = y_q;
            y_d = x_q % y_q;
        end else begin
            g_d     = x_q;
            gdone_d = 1'b1;
            run_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= 1'b0;
            gdone_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            g_q     <= '0;
        end else begin
            run_q   <= run_d;
            gdone_q <= gdone_d;
            x_q     <= x_d;
            y_q     <= y_d;
            g_q     <= g_d;
        end
    end

    assign gdone = gdone_q;
    assign g     = g_q;

endmodule

// File: rtl/pubexp_select_ctrl.sv
// Walks odd candidates e from E_START and returns the first coprime to phi with e < phi.
// Define PUBEXP_TRYCNT_EN to report the number of candidates tested on tries_out.
module pubexp_select_ctrl
    import pubexp_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int E_START   = DEF_E_START,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic                 clk,
    input  logic                 rst,
    pubexp_select_ctrl_if.slave  bus
);

    state_t       state_q, state_d;
    logic [W-1:0] phi_q, phi_d;
    logic [W-1:0] cand_q, cand_d;
    logic [7:0]   tries_q, tries_d;
    logic [W-1:0] e_out_q, e_out_d;
    logic         gdone;
    logic [W-1:0] g;
    logic [W:0]   cand_inc;
    logic [7:0]   tries_inc;
`ifdef PUBEXP_TRYCNT_EN
    logic [7:0]   tries_last_q, tries_last_d;
`endif

    gcd_iter_core #(.W(W)) u_gcd (
        .clk   (clk),
        .rst   (rst),
        .go    (state_q == ST_LAUNCH),
        .a     (cand_q),
        .b     (phi_q),
        .gdone (gdone),
        .g     (g)
    );

    // Next candidate is formed one bit wider so a wrap past W bits is detectable.
    assign cand_inc  = {1'b0, cand_q} + (W+1)'(2);
    assign tries_inc = tries_q + 8'd1;

    always_comb begin
        state_d = state_q;
        phi_d   = phi_q;
        cand_d  = cand_q;
        tries_d = tries_q;
        e_out_d = e_out_q;
`ifdef PUBEXP_TRYCNT_EN
        tries_last_d = tries_last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    phi_d   = bus.phi;
                    cand_d  = W'(E_START);
                    tries_d = '0;
                    state_d = ST_CHK_PHI;
                end
            end
            ST_CHK_PHI: begin
                if (phi_q <= W'(E_START)) begin
                    state_d = ST_FAIL;
`ifdef PUBEXP_TRYCNT_EN
                    tries_last_d = '0;
`endif
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH:   state_d = ST_WAIT_GCD;
            ST_WAIT_GCD: if (gdone) state_d = ST_EVAL;
            ST_EVAL: begin
                tries_d = tries_inc;
`ifdef PUBEXP_TRYCNT_EN
                tries_last_d = tries_inc;
`endif
                if (g == W'(1)) begin
                    e_out_d = cand_q;
                    state_d = ST_DONE;
                end else if (tries_inc == 8'(MAX_TRIES) || cand_inc >= {1'b0, phi_q}
                             || cand_inc[W]) begin
                    state_d = ST_FAIL;
                end else begin
                    cand_d  = cand_inc[W-1:0];
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAIL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phi_q   <= '0;
            cand_q  <= '0;
            tries_q <= '0;
            e_out_q <= '0;
`ifdef PUBEXP_TRYCNT_EN
            tries_last_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            phi_q   <= phi_d;
            cand_q  <= cand_d;
            tries_q <= tries_d;
            e_out_q <= e_out_d;
`ifdef PUBEXP_TRYCNT_EN
            tries_last_q <= tries_last_d;
`endif
        end
    end

    always_comb begin
        bus.busy  = (state_q == ST_CHK_PHI) || (state_q == ST_LAUNCH)
                 || (state_q == ST_WAIT_GCD) || (state_q == ST_EVAL);
        bus.done  = (state_q == ST_DONE);
        bus.fail  = (state_q == ST_FAIL);
        bus.e_out = e_out_q;
`ifdef PUBEXP_TRYCNT_EN
        bus.tries_out = tries_last_q;
`endif
    end

endmodule

// File: tb/tb_pubexp_select_ctrl.sv
// Directed bench for pubexp_select_ctrl; a second instance uses MAX_TRIES=2.
// Checks tries_out as well when PUBEXP_TRYCNT_EN is defined.
module tb_pubexp_select_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pubexp_select_ctrl_if #(.W(8)) bus0 ();
    pubexp_select_ctrl_if #(.W(8)) bus1 ();

    pubexp_select_ctrl #(.W(8), .E_START(3), .MAX_TRIES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pubexp_select_ctrl #(.W(8), .E_START(3), .MAX_TRIES(2)) dut_lim (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for done/fail on the default instance, then checks the result and the one-cycle pulse.
    task automatic wait_result(input string tag, input logic exp_done, input logic [7:0] exp_e,
                               input logic [7:0] exp_tries);
        int cyc = 0;
        bit seen = 0;
        while (cyc < 400 && !seen) begin
            if (bus0.done || bus0.fail) begin
                seen = 1;
            end else begin
                check_output({tag, "_busy"}, 32'(bus0.busy), 32'd1);
                @(negedge clk);
                cyc++;
            end
        end
        check_output({tag, "_finished"}, 32'(seen), 32'd1);
        if (seen) begin
            check_output({tag, "_done"}, 32'(bus0.done), 32'(exp_done));
            check_output({tag, "_fail"}, 32'(bus0.fail), 32'(!exp_done));
            check_output({tag, "_e"}, 32'(bus0.e_out), 32'(exp_e));
            check_output({tag, "_busy_end"}, 32'(bus0.busy), 32'd0);
            if (!exp_done) check_output({tag, "_fail_lat"}, 32'(cyc <= 2), 32'd1);
`ifdef PUBEXP_TRYCNT_EN
            check_output({tag, "_tries"}, 32'(bus0.tries_out), 32'(exp_tries));
`else
            if (exp_tries == 8'hFF) check_output({tag, "_tries_arg"}, 32'(exp_tries), 32'd0);
`endif
            @(negedge clk);
            check_output({tag, "_pulse_end"}, 32'(bus0.done | bus0.fail), 32'd0);
            check_output({tag, "_idle_busy"}, 32'(bus0.busy), 32'd0);
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [7:0] p, input logic hold,
                                  input logic exp_done, input logic [7:0] exp_e,
                                  input logic [7:0] exp_tries);
        bus0.phi   = p;
        bus0.start = 1'b1;
        @(negedge clk);
        if (!hold) bus0.start = 1'b0;
        wait_result(tag, exp_done, exp_e, exp_tries);
    endtask

    initial begin
        bus0.start = 1'b0;
        bus0.phi   = '0;
        bus1.start = 1'b0;
        bus1.phi   = '0;
        repeat (2) @(negedge clk);
        check_output("rst_busy", 32'(bus0.busy), 32'd0);
        check_output("rst_done", 32'(bus0.done), 32'd0);
        check_output("rst_fail", 32'(bus0.fail), 32'd0);
        check_output("rst_e", 32'(bus0.e_out), 32'd0);
        check_output("rst_lim_e", 32'(bus1.e_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        apply_stimulus("phi210", 8'd210, 1'b0, 1'b1, 8'd11, 8'd5);
        apply_stimulus("phi120", 8'd120, 1'b0, 1'b1, 8'd7, 8'd3);
        apply_stimulus("phi3", 8'd3, 1'b0, 1'b0, 8'd7, 8'd0);
        apply_stimulus("phi0", 8'd0, 1'b0, 1'b0, 8'd7, 8'd0);
        apply_stimulus("phi4", 8'd4, 1'b0, 1'b1, 8'd3, 8'd1);
        apply_stimulus("phi255", 8'd255, 1'b0, 1'b1, 8'd7, 8'd3);

        // Start held high: one result, then re-accepted only from IDLE.
        apply_stimulus("phi96_hold", 8'd96, 1'b1, 1'b1, 8'd5, 8'd2);
        @(negedge clk);
        check_output("hold_reaccept_busy", 32'(bus0.busy), 32'd1);
        bus0.start = 1'b0;
        wait_result("phi96_again", 1'b1, 8'd5, 8'd2);

        // Reset in the middle of a GCD run.
        bus0.phi   = 8'd210;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("pre_rst_busy", 32'(bus0.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_busy", 32'(bus0.busy), 32'd0);
        check_output("midrst_done", 32'(bus0.done), 32'd0);
        check_output("midrst_fail", 32'(bus0.fail), 32'd0);
        check_output("midrst_e", 32'(bus0.e_out), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("postrst_quiet", 32'(bus0.done | bus0.fail | bus0.busy), 32'd0);
        apply_stimulus("phi60", 8'd60, 1'b0, 1'b1, 8'd7, 8'd3);

        // Candidate limit on the MAX_TRIES=2 instance.
        begin
            int cyc = 0;
            bus1.phi   = 8'd210;
            bus1.start = 1'b1;
            @(negedge clk);
            bus1.start = 1'b0;
            while (cyc < 400 && !(bus1.done || bus1.fail)) begin
                @(negedge clk);
                cyc++;
            end
            check_output("lim_finished", 32'(bus1.done | bus1.fail), 32'd1);
            check_output("lim_fail", 32'(bus1.fail), 32'd1);
            check_output("lim_done", 32'(bus1.done), 32'd0);
            check_output("lim_e", 32'(bus1.e_out), 32'd0);
`ifdef PUBEXP_TRYCNT_EN
            check_output("lim_tries", 32'(bus1.tries_out), 32'd2);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
